// File: rtl/spi_rx.sv
// SPI receiver: samples mosi on posedge sclk while cs is low and stores completed words.
// Define SPI_RX_FIFO_EN to use a FIFO_DEPTH-entry FIFO instead of a single holding register.
module spi_rx #(
    parameter int BITS       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sclk,
    input  logic                        reset,
    input  logic                        cs,
    input  logic                        mosi,
    output logic [BITS-1:0]             rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [1:0]                  fsm_state
);
    localparam int CW = $clog2(BITS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [BITS-2:0] shift_q;
    logic            excess_q;
    logic            quiet_q;
    logic            armed_q;
    logic            commit;
    logic [BITS-1:0] word;
    logic            pop;

    // Handshake: a word transfers on any posedge where rx_valid and rx_ready are both 1;
    // rx_data is held stable until that happens, and rx_ready alone has no effect.
    assign commit    = (state_q == SHIFT) && !cs && (count_q == CW'(BITS - 1));
    assign word      = {shift_q, mosi};
    assign pop       = rx_valid && rx_ready;
    assign fsm_state = state_q;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            excess_q  <= 1'b0;
            quiet_q   <= 1'b0;
            armed_q   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A frame may only start after a posedge that saw cs high.
            armed_q   <= cs;
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (!cs) begin
                        if (armed_q) begin
                            shift_q <= (BITS-1)'(mosi);
                            count_q <= CW'(1);
                            state_q <= SHIFT;
                            busy    <= 1'b1;
                        end else begin
                            // Joined mid-frame after reset: sit it out without flagging.
                            quiet_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    if (cs) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        count_q   <= '0;
                        shift_q   <= '0;
                    end else if (commit) begin
                        state_q <= HOLD;
                        busy    <= 1'b0;
                        count_q <= '0;
                    end else begin
                        shift_q <= (shift_q << 1) | (BITS-1)'(mosi);
                        count_q <= count_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cs) begin
                        state_q   <= IDLE;
                        frame_err <= excess_q && !quiet_q;
                        excess_q  <= 1'b0;
                        quiet_q   <= 1'b0;
                    end else begin
                        excess_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [LW-1:0]   level_q;
    logic            full;

    assign full = (level_q == LW'(FIFO_DEPTH));

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= commit && full && !pop;
            // When full, a simultaneous pop frees the slot the write pointer lands on.
            if (commit && (!full || pop)) begin
                mem_q[wr_q] <= word;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (commit && !full && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !commit) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    assign rx_data  = mem_q[rd_q];
    assign rx_valid = (level_q != '0);
    assign rx_level = level_q;
`else
    logic [BITS-1:0] hold_q;
    logic            valid_q;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            hold_q   <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= commit && valid_q && !pop;
            if (commit && (!valid_q || pop)) begin
                hold_q  <= word;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = valid_q;
    assign rx_level = LW'(valid_q);
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: directed scenarios plus random frames against a run-length reference model.
module tb_spi_rx;
    localparam int BITS       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic            sclk     = 1'b0;
    logic            reset    = 1'b1;
    logic            cs       = 1'b1;
    logic            mosi     = 1'b0;
    logic            rx_ready = 1'b0;
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic [LW-1:0]   rx_level;
    logic            busy;
    logic            frame_err;
    logic            overflow;
    logic [1:0]      fsm_state;

    spi_rx #(.BITS(BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sclk      (sclk),
        .reset     (reset),
        .cs        (cs),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    always #5 sclk = ~sclk;

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;
    int ovf_seen    = 0;

    // Reference model: words waiting in storage, plus the current cs-low run.
    logic [BITS-1:0] exp_q[$];
    logic            armed;
    logic            run_valid;
    int              run_len;
    logic [31:0]     run_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        armed     = 1'b0;
        run_valid = 1'b0;
        run_len   = 0;
        run_word  = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_level", rx_level, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
    endtask

    task automatic step(input logic c, input logic d, input logic rdy, input logic rst_pulse);
        logic pop, commit, full_before, e_err, e_ovf, e_busy;
        @(negedge sclk);
        cs       = c;
        mosi     = d;
        rx_ready = rdy;
        if (rst_pulse) begin
            reset = 1'b1;
            #1;
            check_reset_outputs();
            model_reset();
            #1;
            reset = 1'b0;
        end
        @(posedge sclk);
        full_before = (exp_q.size() == CAP);
        pop         = (exp_q.size() > 0) && rdy;
        commit      = 1'b0;
        e_err       = 1'b0;
        e_ovf       = 1'b0;
        if (!c) begin
            if (run_len == 0) begin
                run_valid = armed;
                run_word  = '0;
            end
            run_len++;
            if (run_len <= BITS) run_word = (run_word << 1) | 32'(d);
            if (run_valid && run_len == BITS) commit = 1'b1;
        end else begin
            if (run_len > 0 && run_valid && run_len != BITS) e_err = 1'b1;
            run_len = 0;
        end
        armed  = c;
        e_busy = !c && run_valid && (run_len < BITS);
        if (pop) void'(exp_q.pop_front());
        if (commit) begin
            if (full_before && !pop) e_ovf = 1'b1;
            else exp_q.push_back(run_word[BITS-1:0]);
        end
        #1;
        check("valid", rx_valid, (exp_q.size() > 0));
        check("level", rx_level, exp_q.size());
        check("busy", busy, e_busy);
        check("frame_err", frame_err, e_err);
        check("overflow", overflow, e_ovf);
        if (exp_q.size() > 0) check("data", rx_data, exp_q[0]);
        err_seen += int'(frame_err);
        ovf_seen += int'(overflow);
    endtask

    // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the completing bit
    task automatic send_frame(input logic [BITS-1:0] word, input int nbits, input int mode);
        logic b, r;
        for (int i = 0; i < nbits; i++) begin
            if (i < BITS) b = word[BITS-1-i];
            else b = 1'($urandom_range(0, 1));
            case (mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = (i == BITS - 1);
            endcase
            step(1'b0, b, r, 1'b0);
        end
        if (mode == 1) r = 1'b1;
        else if (mode == 2) r = 1'($urandom_range(0, 1));
        else r = 1'b0;
        step(1'b1, 1'($urandom_range(0, 1)), r, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, o0;
        logic [BITS-1:0] w;

        repeat (2) @(posedge sclk);
        #1;
        check_reset_outputs();
        model_reset();
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Clean frame A5
        e0 = err_seen; o0 = ovf_seen;
        send_frame(8'hA5, 8, 0);
        check("a5_data", rx_data, 8'hA5);
        check("a5_ferr_cnt", err_seen - e0, 0);
        check("a5_ovf_cnt", ovf_seen - o0, 0);
        drain(2);

        // Aborted 3C followed by 81
        e0 = err_seen;
        send_frame(8'h3C, 5, 0);
        send_frame(8'h81, 8, 0);
        check("abort_ferr_cnt", err_seen - e0, 1);
        check("abort_data", rx_data, 8'h81);
        check("abort_level", rx_level, 1);
        drain(2);

        // Ten-bit frame, first eight F0
        e0 = err_seen;
        send_frame(8'hF0, 10, 0);
        check("excess_ferr_cnt", err_seen - e0, 1);
        check("excess_data", rx_data, 8'hF0);
        drain(2);

        // Fill storage with 01..05 while the consumer stalls
        o0 = ovf_seen;
        for (int k = 1; k <= 5; k++) send_frame(BITS'(k), 8, 0);
        check("fill_ovf_cnt", ovf_seen - o0, 5 - CAP);
        check("fill_level", rx_level, CAP);
        for (int k = 1; k <= CAP; k++) begin
            check("fill_pop_data", rx_data, k);
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        drain(1);

        // Pop and commit on the same edge
        send_frame(8'h11, 8, 0);
        o0 = ovf_seen;
        send_frame(8'h55, 8, 3);
        check("same_edge_ovf_cnt", ovf_seen - o0, 0);
        check("same_edge_level", rx_level, 1);
        check("same_edge_data", rx_data, 8'h55);
        drain(2);

        // Reset pulse mid-frame with cs held low
        e0 = err_seen;
        w = 8'hC3;
        for (int i = 0; i < 4; i++) step(1'b0, w[BITS-1-i], 1'b0, 1'b0);
        step(1'b0, w[3], 1'b0, 1'b1);
        for (int i = 5; i < 8; i++) step(1'b0, w[BITS-1-i], 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_valid", rx_valid, 0);
        check("rst_mid_ferr_cnt", err_seen - e0, 0);
        send_frame(8'h7E, 8, 0);
        check("after_rst_data", rx_data, 8'h7E);
        drain(2);

        // Random frames, lengths, gaps, consumer behaviour and occasional resets
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 11) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            send_frame(BITS'($urandom), $urandom_range(1, BITS + 3), $urandom_range(0, 3));
            for (int g = 0; g < $urandom_range(0, 2); g++)
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain(CAP + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
